// File: rtl/dst_pkg.sv
// ---------------------------------------------------------------------------
// dst_pkg
// Shared constants for the 4x4 forward DST column stage: default widths,
// the A4 coefficient matrix and the column-stage FSM state encoding.
// ---------------------------------------------------------------------------
package dst_pkg;

    localparam int DST_IN_W    = 22;
    localparam int DST_COEFF_W = 8;
    localparam int DST_OUT_W   = 16;
    localparam int DST_SHIFT   = 8;

    // A4 stored row-major, 8-bit two's complement:
    //   { 29,  55,  74,  84}
    //   { 74,  74,   0, -74}
    //   { 84, -29, -74,  55}
    //   { 55, -84,  74, -29}
    localparam logic [0:3][0:3][7:0] DST_A4 = {
        8'd29, 8'd55, 8'd74, 8'd84,
        8'd74, 8'd74, 8'd0,  8'hB6,
        8'd84, 8'hE3, 8'hB6, 8'd55,
        8'd55, 8'hAC, 8'd74, 8'hE3
    };

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } dst_state_e;

    function automatic logic signed [7:0] dst_a4_coef(input logic [1:0] k,
                                                      input logic [1:0] i);
        return $signed(DST_A4[k][i]);
    endfunction

endpackage

// File: rtl/dst_round_sat.sv
// ---------------------------------------------------------------------------
// dst_round_sat
// Round-half-up, arithmetic right shift and reduction to OUT_W bits for one
// column-stage dot product.
//
// Build option: DST_COL_SAT_EN
//   defined   -> result clipped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
//   undefined -> result truncated to its low OUT_W bits (two's-complement wrap)
//
// Ports:
//   i_acc  in   signed [ACC_W-1:0]  dot product
//   o_res  out  signed [OUT_W-1:0]  rounded, shifted, reduced coefficient
// ---------------------------------------------------------------------------
module dst_round_sat #(
    parameter int ACC_W = 32,
    parameter int SHIFT = 8,
    parameter int OUT_W = 16
) (
    input  logic signed [ACC_W-1:0] i_acc,
    output logic signed [OUT_W-1:0] o_res
);

    localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (SHIFT - 1);

    logic signed [ACC_W-1:0] w_sum;

    assign w_sum = i_acc + RND;

`ifdef DST_COL_SAT_EN
    // MAXV = 0..01..1 (OUT_W-1 ones), MINV is its bitwise complement.
    localparam logic signed [ACC_W-1:0] MAXV =
        {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

    logic signed [ACC_W-1:0] w_shr;

    assign w_shr = w_sum >>> SHIFT;

    always_comb begin
        if (w_shr > MAXV) begin
            o_res = MAXV[OUT_W-1:0];
        end else if (w_shr < MINV) begin
            o_res = MINV[OUT_W-1:0];
        end else begin
            o_res = w_shr[OUT_W-1:0];
        end
    end
`else
    assign o_res = OUT_W'(w_sum >>> SHIFT);
`endif

endmodule

// File: rtl/dst_col_transform.sv
// ---------------------------------------------------------------------------
// dst_col_transform
// Column stage of the 4x4 forward DST: Y = A4 * X, one output row per cycle,
// with rounding shift and reduction to OUT_W. Holds one block; the next block
// is accepted on the cycle the last row of the current one is handed off.
//
// Build option: DST_COL_SAT_EN (saturate instead of wrap, see dst_round_sat)
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   in_valid     in   in_block valid
//   in_ready     out  block can be accepted this cycle
//   in_block     in   X[i][j], 16 x IN_W signed
//   out_valid    out  out_row valid
//   out_ready    in   downstream accepts out_row
//   out_row      out  Y[k][0..3], 4 x OUT_W signed
//   out_row_idx  out  k
//   out_last     out  k == 3
//
// state | meaning
// IDLE  | no block held, in_ready high
// BUSY  | block held, presenting row r_k
// ---------------------------------------------------------------------------
module dst_col_transform
    import dst_pkg::*;
#(
    parameter int IN_W    = DST_IN_W,
    parameter int COEFF_W = DST_COEFF_W,
    parameter int ACC_W   = IN_W + COEFF_W + 2,
    parameter int SHIFT   = DST_SHIFT,
    parameter int OUT_W   = DST_OUT_W
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic signed [0:3][0:3][IN_W-1:0]    in_block,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic signed [0:3][OUT_W-1:0]        out_row,
    output logic [1:0]                          out_row_idx,
    output logic                                out_last
);

    dst_state_e                     r_state;
    logic [1:0]                     r_k;
    logic [0:3][0:3][IN_W-1:0]      r_block;

    logic                           w_busy;
    logic                           w_last_take;
    logic signed [COEFF_W-1:0]      w_coef [0:3];
    logic signed [ACC_W-1:0]        w_acc  [0:3];
    logic signed [OUT_W-1:0]        w_res  [0:3];

    assign w_busy      = (r_state == BUSY);
    assign w_last_take = w_busy && (r_k == 2'd3) && out_ready;

    // Gated by rst so nothing upstream sees ready during the reset cycle.
    assign in_ready = !rst && ((r_state == IDLE) || w_last_take);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_k     <= 2'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_block <= in_block;
                        r_k     <= 2'd0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (out_ready) begin
                        if (r_k != 2'd3) begin
                            r_k <= r_k + 2'd1;
                        end else if (in_valid) begin
                            r_block <= in_block;
                            r_k     <= 2'd0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Row k of A4 times every column of the held block.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_coef[i] = COEFF_W'(dst_a4_coef(r_k, 2'(i)));
        end
        for (int j = 0; j < 4; j++) begin
            w_acc[j] = '0;
            for (int i = 0; i < 4; i++) begin
                w_acc[j] = w_acc[j]
                         + ACC_W'(w_coef[i]) * ACC_W'($signed(r_block[i][j]));
            end
        end
    end

    for (genvar j = 0; j < 4; j++) begin : g_col
        dst_round_sat #(
            .ACC_W (ACC_W),
            .SHIFT (SHIFT),
            .OUT_W (OUT_W)
        ) u_round_sat (
            .i_acc (w_acc[j]),
            .o_res (w_res[j])
        );
    end

    always_comb begin
        out_valid   = w_busy;
        out_row_idx = 2'd0;
        out_last    = 1'b0;
        out_row     = '0;
        if (w_busy) begin
            out_row_idx = r_k;
            out_last    = (r_k == 2'd3);
            for (int j = 0; j < 4; j++) begin
                out_row[j] = w_res[j];
            end
        end
    end

endmodule

// File: tb/tb_dst_col_transform.sv
module tb_dst_col_transform;

    typedef logic [0:3][0:3][21:0] blk_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    blk_t              in_block;
    logic              out_valid;
    logic              out_ready;
    logic [0:3][15:0]  out_row;
    logic [1:0]        out_row_idx;
    logic              out_last;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dst_col_transform dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_block    (in_block),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row     (out_row),
        .out_row_idx (out_row_idx),
        .out_last    (out_last)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Presents b until it is accepted; returns 1 ns after the capturing edge.
    task automatic send_block(input blk_t b);
        int t;
        in_block = b;
        in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic blk_t blk_one(input int i, input int j, input int v);
        blk_t b;
        b = '0;
        b[i][j] = 22'(v);
        return b;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %0b want 0", in_ready); else n_pass++;
        n_checks++;
        if ({out_valid, out_last, out_row_idx} !== 4'b0) $display("FAIL rst_ctrl: got v=%0b l=%0b idx=%0d want 0", out_valid, out_last, out_row_idx); else n_pass++;
        n_checks++;
        if (out_row !== 64'b0) $display("FAIL rst_row: got %h want 0", out_row); else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL post_rst: got rdy=%0b v=%0b want rdy=1 v=0", in_ready, out_valid); else n_pass++;
    endtask

    task automatic test_impulse();
        int exp0 [4] = '{29, 74, 84, 55};
        out_ready = 1'b1;
        send_block(blk_one(0, 0, 256));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_row_idx !== 2'(k) || out_last !== (k == 3)) $display("FAIL imp_ctrl k=%0d: got v=%0b idx=%0d last=%0b", k, out_valid, out_row_idx, out_last); else n_pass++;
            n_checks++;
            if (out_row[0] !== 16'(exp0[k])) $display("FAIL imp_col0 k=%0d: got %0d want %0d", k, $signed(out_row[0]), exp0[k]); else n_pass++;
            n_checks++;
            if (out_row[1] !== 16'd0 || out_row[2] !== 16'd0 || out_row[3] !== 16'd0) $display("FAIL imp_col123 k=%0d: got %h want 0", k, out_row); else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || out_row !== 64'b0) $display("FAIL imp_after: got v=%0b row=%h want v=0 row=0", out_valid, out_row); else n_pass++;
    endtask

    task automatic test_rounding();
        blk_t b;
        b = blk_one(0, 0, 5);
        b[3][0] = 22'(-3);
        send_block(b);
        @(negedge clk);
        n_checks++;
        if (out_row[0] !== 16'd0) $display("FAIL rnd_mix: got %0d want 0", $signed(out_row[0])); else n_pass++;
        send_block(blk_one(0, 0, 5));
        @(negedge clk);
        n_checks++;
        if (out_row[0] !== 16'd1) $display("FAIL rnd_pos: got %0d want 1", $signed(out_row[0])); else n_pass++;
        send_block(blk_one(3, 0, -3));
        @(negedge clk);
        n_checks++;
        if (out_row[0] !== 16'hFFFF) $display("FAIL rnd_neg: got %0d want -1", $signed(out_row[0])); else n_pass++;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_overflow();
        blk_t b;
        logic [15:0] exp_v;
`ifdef DST_COL_SAT_EN
        exp_v = 16'd32767;
`else
        exp_v = 16'd16383;
`endif
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                b[i][j] = 22'd2097151;
        send_block(b);
        @(negedge clk);
        n_checks++;
        if (out_row[0] !== exp_v) $display("FAIL ovf_r0c0: got %0d want %0d", $signed(out_row[0]), $signed(exp_v)); else n_pass++;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_backpressure();
        blk_t b;
        logic [0:3][15:0] held;
        b = blk_one(0, 0, 256);
        b[1][1] = 22'd256;
        out_ready = 1'b1;
        send_block(b);
        @(negedge clk);
        n_checks++;
        if (out_row_idx !== 2'd0 || out_row[1] !== 16'd55) $display("FAIL bp_row0: got idx=%0d c1=%0d want 0/55", out_row_idx, $signed(out_row[1])); else n_pass++;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        held = '0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            if (s == 0) held = out_row;
            n_checks++;
            if (out_valid !== 1'b1 || out_row_idx !== 2'd1 || in_ready !== 1'b0) $display("FAIL bp_stall s=%0d: got v=%0b idx=%0d rdy=%0b want 1/1/0", s, out_valid, out_row_idx, in_ready); else n_pass++;
            n_checks++;
            if (out_row[0] !== 16'd74 || out_row[1] !== 16'd74 || out_row !== held) $display("FAIL bp_data s=%0d: got %h want c0=74 c1=74 stable", s, out_row); else n_pass++;
            @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_row_idx !== 2'd1 || in_ready !== 1'b0) $display("FAIL bp_release: got idx=%0d rdy=%0b want 1/0", out_row_idx, in_ready); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (out_row_idx !== 2'd2 || out_row[0] !== 16'd84 || out_row[1] !== 16'hFFE3) $display("FAIL bp_row2: got idx=%0d c0=%0d c1=%0d want 2/84/-29", out_row_idx, $signed(out_row[0]), $signed(out_row[1])); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (out_row_idx !== 2'd3 || out_row[1] !== 16'hFFAC || out_last !== 1'b1) $display("FAIL bp_row3: got idx=%0d c1=%0d last=%0b want 3/-84/1", out_row_idx, $signed(out_row[1]), out_last); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int exp_a [4] = '{29, 74, 84, 55};
        int exp_b [4] = '{58, 148, 168, 110};
        int e;
        out_ready = 1'b1;
        send_block(blk_one(0, 0, 256));
        in_valid = 1'b1;
        in_block = blk_one(0, 0, 512);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            e = (c < 4) ? exp_a[c] : exp_b[c - 4];
            n_checks++;
            if (out_valid !== 1'b1 || out_row_idx !== 2'(c % 4)) $display("FAIL b2b_seq c=%0d: got v=%0b idx=%0d want 1/%0d", c, out_valid, out_row_idx, c % 4); else n_pass++;
            n_checks++;
            if (in_ready !== (c % 4 == 3)) $display("FAIL b2b_ready c=%0d: got %0b want %0b", c, in_ready, (c % 4 == 3)); else n_pass++;
            n_checks++;
            if (out_row[0] !== 16'(e)) $display("FAIL b2b_data c=%0d: got %0d want %0d", c, $signed(out_row[0]), e); else n_pass++;
            if (c == 3) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL b2b_end: got v=%0b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_reset_mid_block();
        out_ready = 1'b1;
        send_block(blk_one(0, 0, 256));
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (out_row_idx !== 2'd2) $display("FAIL rmb_pre: got idx=%0d want 2", out_row_idx); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL rmb_rdy_in_rst: got %0b want 0", in_ready); else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL rmb_after: got v=%0b rdy=%0b want 0/1", out_valid, in_ready); else n_pass++;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) $display("FAIL rmb_no_rows c=%0d: got v=%0b want 0", c, out_valid); else n_pass++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_block  = '0;
        out_ready = 1'b1;
        test_reset();
        test_impulse();
        test_rounding();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_block();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dst_col_transform.md
# dst_col_transform

Second (column) stage of the 4x4 forward DST. Accepts a row-transformed 4x4 block via valid/ready and multiplies it on the left by the A4 matrix, one output row per cycle. Applies the second-stage rounding shift and emits one row of four coefficients per handshake to the quantiser. Holds one block; a new block is accepted on the cycle its last row leaves, giving 4 cycles per block sustained.

## Interface

Parameters:
- IN_W, 22, width of each signed input element; matches the row-stage output width.
- COEFF_W, 8, signed width of the A4 coefficients.
- ACC_W, IN_W+COEFF_W+2, internal dot-product width.
- SHIFT, 8, second-stage rounding shift; legal range 1..ACC_W-OUT_W.
- OUT_W, 16, signed width of each output coefficient.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_block is valid.
- in_ready  out  1  block can be accepted this cycle.
- in_block  in  signed [IN_W-1:0] [0:3][0:3]  row-transformed block X[i][j].
- out_valid  out  1  out_row is valid.
- out_ready  in  1  downstream accepts out_row.
- out_row  out  signed [OUT_W-1:0] [0:3]  row k of the result: Y[k][0..3].
- out_row_idx  out  2  k, the index of the current row.
- out_last  out  1  high when k==3.

## Operation

- A4 rows are {29,55,74,84}, {74,74,0,-74}, {84,-29,-74,55} and {55,-84,74,-29}.
- Each output element is computed as:
  - acc = sum over i of A4[k][i]*X[i][j], evaluated at ACC_W.
  - Y[k][j] = (acc + 2^(SHIFT-1)) >>> SHIFT, with an arithmetic shift.
  - The result is then reduced to OUT_W bits (see Configuration).
- The FSM has two states, IDLE and BUSY, plus a 2-bit row counter k and a block register holding 16 elements of IN_W bits.
- IDLE:
  - in_ready=1.
  - On in_valid, capture in_block, set k=0 and go to BUSY.
- BUSY:
  - out_valid=1.
  - On out_ready with k<3, increment k.
  - On out_ready with k==3:
    - If in_valid, capture the new block and set k=0, staying in BUSY.
    - Otherwise go to IDLE.
- in_ready equals IDLE, OR (BUSY AND k==3 AND out_ready), with both terms forced low while rst is high.
- Stall: while out_valid && !out_ready, out_row, out_row_idx and out_last stay stable, and the block register is not written.
- While out_valid is low, out_row, out_row_idx and out_last read 0.
- Outputs are derived only from the block register and k. There is no combinational path from in_* to out_*.

## Timing

- Reset values: state IDLE, k=0, out_valid=0, out_row=0, out_row_idx=0, out_last=0. in_ready=0 during the reset cycle and 1 in the first cycle after reset.
- Latency: a block accepted at edge T presents row 0 in the cycle after T.
- Rows 0..3 then follow on consecutive cycles if out_ready stays high.
- Throughput: one block per 4 cycles when in_valid and out_ready are held high, with no bubble between blocks.
- Reset mid-block: the remaining rows are discarded, out_valid is 0 in the following cycle, and the block register contents are don't-care.
- in_valid with in_ready low: no capture. The upstream stage must hold in_block stable.

## Configuration

- `DST_COL_SAT_EN` defined: the shifted result is clipped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- `DST_COL_SAT_EN` undefined: the shifted result is truncated to its low OUT_W bits (two's-complement wrap).

## Structure

- Shared package `dst_pkg`:
  - the A4 coefficient constant;
  - default widths (IN_W, COEFF_W, OUT_W, SHIFT);
  - the state enum {IDLE, BUSY}.
- One sub-module, `dst_round_sat`: parameterised by ACC_W, SHIFT and OUT_W, it takes acc and performs the round, shift and saturate/wrap step.
- The top level instantiates four copies of `dst_round_sat`, one per column j.
- The four dot products are combinational from the block register and row k of A4.

## Test plan

1. Column impulse: X[0][0]=256, all other elements 0, out_ready=1.
   - Rows k=0..3 give out_row[0] = 29, 74, 84, 55; out_row[1..3]=0.
   - out_last is high on row 3 only.
2. Rounding: X[0][0]=5 and X[3][0]=-3, all others 0.
   - Row 0 is computed as (145-252+128)>>>8 = 21>>>8 = 0.
   - Separately, X[0][0]=5 alone gives row 0 col 0 = 1, and X[3][0]=-3 alone gives -1.
3. Overflow: every X=2097151.
   - Row 0 col 0 = 32767 with `DST_COL_SAT_EN`.
   - Row 0 col 0 = 16383 without it (1982463 wrapped to 16 bits).
4. Backpressure: out_ready=0 for 3 cycles while k=1.
   - out_row_idx stays 1 and out_row is stable.
   - in_ready=0 throughout; row 2 appears only after out_ready returns high.
5. Back-to-back: two blocks with in_valid held high and out_ready=1.
   - 8 consecutive valid rows with out_row_idx sequence 0,1,2,3,0,1,2,3.
   - in_ready pulses high only in the row-3 cycle of the first block, and the second block's row 0 follows with no gap.
6. Reset mid-block: rst asserted for 1 cycle while k=2.
   - The next cycle has out_valid=0 and in_ready=1.
   - No further rows of the aborted block are emitted.
